store_narrow_buffer: RTL and testbench

//  Store-side counterpart to immediate/load sign extension: narrows 32-bit register

---
 rtl/store_narrow_buffer.sv | 74 +++++++
 tb/tb_store_narrow_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows register stores to byte lanes and buffers them toward data memory
module store_narrow_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [1:0]       st_size,
    output logic             mem_req,
    input  logic             mem_ack,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic             misalign,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [29:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [3:0]       be_mem   [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [1:0]       lane;
    logic             legal, accept, enq, deq;
    logic [31:0]      wdata;
    logic [3:0]       be;

    assign lane      = st_addr[1:0];
    assign st_ready  = count != CNT_W'(DEPTH);
    assign mem_req   = count != '0;
    assign accept    = st_valid & st_ready;
    assign enq       = accept & legal;
    assign deq       = mem_req & mem_ack;
    assign mem_addr  = {addr_mem[rd_ptr], 2'b00};
    assign mem_wdata = data_mem[rd_ptr];
    assign mem_be    = be_mem[rd_ptr];

    // Lane-align the store data and build byte enables; flag sizes/offsets memory cannot take
    always_comb begin
        legal = (st_size == 2'b00) | ((st_size == 2'b01) & ~lane[0]) | ((st_size == 2'b10) & (lane == 2'b00));
        be    = (st_size == 2'b00) ? 4'b0001 << lane : (st_size == 2'b01) ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata = (st_size == 2'b00) ? {24'b0, st_data[7:0]} << {lane, 3'b000}
              : (st_size == 2'b01) ? (lane[1] ? {st_data[15:0], 16'b0} : {16'b0, st_data[15:0]})
              : st_data;
    end

    // Entry storage; stale contents are harmless because reset only clears the pointers/count
    always_ff @(posedge Clk) begin
        if (enq) begin
            addr_mem[wr_ptr] <= st_addr[31:2];
            data_mem[wr_ptr] <= wdata;
            be_mem[wr_ptr]   <= be;
        end
    end

    // Occupancy, pointers and the one-cycle misalign pulse
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            misalign <= 1'b0;
        end else begin
            count    <= count + CNT_W'(enq) - CNT_W'(deq);
            rd_ptr   <= rd_ptr + PTR_W'(deq);
            wr_ptr   <= wr_ptr + PTR_W'(enq);
            misalign <= accept & ~legal;
        end
    end
endmodule

// File: tb/tb_store_narrow_buffer.sv
// tb_store_narrow_buffer: randomized bench against a queue-based store buffer model
module tb_store_narrow_buffer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             Clk = 1'b0;
    logic             Rst_n = 1'b0;
    logic             st_valid = 1'b0;
    logic             st_ready;
    logic [31:0]      st_addr = '0;
    logic [31:0]      st_data = '0;
    logic [1:0]       st_size = '0;
    logic             mem_req;
    logic             mem_ack = 1'b0;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             misalign;
    logic [CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  q_be[$];
    logic        exp_mis = 1'b0;

    store_narrow_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .misalign(misalign), .count(count)
    );

    always #5 Clk = ~Clk;

    // Byte-by-byte placement of the low n bytes of d starting at lane a%4
    function automatic void narrow(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                                   output logic ok, output logic [31:0] w, output logic [3:0] b);
        int n;
        int l;
        n  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        l  = int'(a % 4);
        ok = (s != 2'd3) && (l % n == 0);
        w  = '0;
        b  = '0;
        for (int i = 0; i < n; i++)
            if (l + i < 4) begin
                b[l + i] = 1'b1;
                w[8 * (l + i) +: 8] = d[8 * i +: 8];
            end
    endfunction

    // One clock of stimulus; the model decides acceptance/drain from its own queue occupancy
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        input logic k, output logic acc);
        logic ok;
        logic [31:0] w;
        logic [3:0] b;
        logic dq;
        st_valid = v; st_addr = a; st_data = d; st_size = s; mem_ack = k;
        narrow(a, d, s, ok, w, b);
        acc = Rst_n && v && (q_addr.size() < DEPTH);
        dq  = Rst_n && k && (q_addr.size() != 0);
        @(posedge Clk); #1;
        if (!Rst_n) begin
            q_addr.delete(); q_data.delete(); q_be.delete();
        end else begin
            if (dq) begin
                void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_be.pop_front());
            end
            if (acc && ok) begin
                q_addr.push_back({a[31:2], 2'b00}); q_data.push_back(w); q_be.push_back(b);
            end
        end
        exp_mis  = acc && !ok;
        st_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    task automatic test_reset();
        logic acc;
        Rst_n = 1'b0;
        step(1'b1, 32'h0, 32'h1, 2'd2, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, acc);
        Rst_n = 1'b1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b want 1", st_ready); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
    endtask

    task automatic test_byte();
        logic acc;
        step(1'b1, 32'h0000_1003, 32'hAABB_CC5A, 2'd0, 1'b0, acc);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sb_req got %b want 1", mem_req); end
        checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got %h want 00001000", mem_addr); end
        checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b want 1000", mem_be); end
        checks++; if (mem_wdata !== 32'h5A00_0000) begin errors++; $display("FAIL sb_wdata got %h want 5a000000", mem_wdata); end
        checks++; if (mem_wdata !== q_data[0]) begin errors++; $display("FAIL sb_model got %h want %h", mem_wdata, q_data[0]); end
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, acc);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL sb_drain got %0d want 0", count); end
    endtask

    task automatic test_half();
        logic acc;
        step(1'b1, 32'h0000_2002, 32'h1234_8765, 2'd1, 1'b0, acc);
        checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", mem_be); end
        checks++; if (mem_wdata !== 32'h8765_0000) begin errors++; $display("FAIL sh_wdata got %h want 87650000", mem_wdata); end
        checks++; if (mem_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr got %h want 00002000", mem_addr); end
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, acc);
        step(1'b1, 32'h0000_2001, 32'h1234_8765, 2'd1, 1'b0, acc);
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL sh_mis_pulse got %b want 1", misalign); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL sh_mis_count got %0d want 0", count); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sh_mis_req got %b want 0", mem_req); end
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, acc);
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL sh_mis_end got %b want 0", misalign); end
        step(1'b1, 32'h0000_3004, 32'h0, 2'd3, 1'b0, acc);
        checks++; if (misalign !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL rsvd_size got mis=%b cnt=%0d want mis=1 cnt=0", misalign, count); end
        step(1'b1, 32'h0000_3006, 32'h0, 2'd2, 1'b0, acc);
        checks++; if (misalign !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL sw_mis got mis=%b cnt=%0d want mis=1 cnt=0", misalign, count); end
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, acc);
    endtask

    task automatic test_full();
        logic acc;
        logic pending;
        logic [31:0] got[$];
        for (int i = 0; i < 5; i++) step(1'b1, 32'(4 * i), 32'(i + 100), 2'd2, 1'b0, acc);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", st_ready); end
        pending = 1'b1;
        for (int c = 0; c < 20 && got.size() < 5; c++) begin
            if (mem_req) got.push_back(mem_addr);
            step(pending, 32'h10, 32'd104, 2'd2, 1'b1, acc);
            if (acc) pending = 1'b0;
        end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL full_drain_len got %0d want 5", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 32'(4 * i)) begin errors++; $display("FAIL full_order[%0d] got %h want %h", i, got[i], 32'(4 * i)); end
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_end_count got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        logic acc;
        step(1'b1, 32'h100, 32'h11, 2'd2, 1'b0, acc);
        step(1'b1, 32'h104, 32'h22, 2'd2, 1'b0, acc);
        step(1'b1, 32'h108, 32'h33, 2'd2, 1'b1, acc);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", count); end
        checks++; if (mem_addr !== 32'h104 || mem_wdata !== 32'h22) begin errors++; $display("FAIL b2b_head got %h/%h want 00000104/00000022", mem_addr, mem_wdata); end
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, acc);
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, acc);
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, acc);
        checks++; if (count !== 3'd0 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_idle_ack got cnt=%0d req=%b want 0/0", count, mem_req); end
    endtask

    task automatic test_random_wrap();
        logic acc;
        int n;
        int c;
        n = 0;
        for (c = 0; c < 3000 && (n < 3 * DEPTH || q_addr.size() != 0); c++) begin
            checks++; if (int'(count) != q_addr.size()) begin errors++; $display("FAIL rnd_count got %0d want %0d", count, q_addr.size()); end
            checks++; if (mem_req !== (q_addr.size() != 0)) begin errors++; $display("FAIL rnd_req got %b want %b", mem_req, q_addr.size() != 0); end
            checks++; if (st_ready !== (q_addr.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready got %b want %b", st_ready, q_addr.size() != DEPTH); end
            if (q_addr.size() != 0) begin
                checks++;
                if (mem_addr !== q_addr[0] || mem_wdata !== q_data[0] || mem_be !== q_be[0]) begin
                    errors++;
                    $display("FAIL rnd_head got %h/%h/%b want %h/%h/%b", mem_addr, mem_wdata, mem_be, q_addr[0], q_data[0], q_be[0]);
                end
            end
            step((n < 3 * DEPTH) && ($urandom_range(0, 3) != 0), $urandom, $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), acc);
            if (acc) n++;
            checks++; if (misalign !== exp_mis) begin errors++; $display("FAIL rnd_misalign got %b want %b", misalign, exp_mis); end
        end
        checks++; if (c >= 3000) begin errors++; $display("FAIL rnd_timeout accepted %0d left %0d", n, q_addr.size()); end
    endtask

    task automatic test_reset_mid();
        logic acc;
        for (int i = 0; i < 3; i++) step(1'b1, 32'(8 * i), 32'(i), 2'd2, 1'b0, acc);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rmid_fill got %0d want 3", count); end
        Rst_n = 1'b0;
        step(1'b1, 32'h80, 32'h55, 2'd2, 1'b0, acc);
        Rst_n = 1'b1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", count); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_req got %b want 0", mem_req); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", st_ready); end
        step(1'b1, 32'h40, 32'hDEAD_BEEF, 2'd2, 1'b0, acc);
        checks++; if (mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'hF) begin errors++; $display("FAIL rmid_sw got %h/%h/%b want 00000040/deadbeef/1111", mem_addr, mem_wdata, mem_be); end
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, acc);
        checks++; if (count !== 3'd0 || mem_req !== 1'b0) begin errors++; $display("FAIL rmid_drain got cnt=%0d req=%b want 0/0", count, mem_req); end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_half();
        test_full();
        test_back_to_back();
        test_random_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
